// File: rtl/mul_ctrl_pkg.sv
// Shared definitions for the RV32M multiply sequencer: op encodings, FSM states
// and the legal range of the multiplier-array latency.
package mul_ctrl_pkg;

   typedef enum logic [1:0] {
      OP_MUL    = 2'b00,
      OP_MULH   = 2'b01,
      OP_MULHSU = 2'b10,
      OP_MULHU  = 2'b11
   } mul_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   localparam int MUL_LAT_MIN = 1;
   localparam int MUL_LAT_MAX = 15;
   localparam int CNT_W       = 4;

   function automatic bit mul_latency_ok(input int lat);
      return (lat >= MUL_LAT_MIN) && (lat <= MUL_LAT_MAX);
   endfunction

endpackage

// File: rtl/mul_sign_fixup.sv
// Turns the unsigned magnitude product back into the signed result and picks
// the low word (MUL) or the high word (MULH/MULHSU/MULHU).
module mul_sign_fixup
   import mul_ctrl_pkg::*;
#(
   parameter int XLEN = 32
)(
   input  logic [2*XLEN-1:0] prod_i,
   input  logic              neg_i,
   input  mul_op_e           op_i,
   output logic [XLEN-1:0]   result_o
);

   logic [2*XLEN-1:0] fixed;

   always_comb begin
      fixed    = neg_i ? (~prod_i + 1'b1) : prod_i;
      result_o = (op_i == OP_MUL) ? fixed[XLEN-1:0] : fixed[2*XLEN-1:XLEN];
   end

endmodule

// File: rtl/int_mul_controller.sv
// Sequencer between execute and the 32x32 unsigned multiplier array.
// Optional single-entry result reuse cache: define MUL_RESULT_REUSE_EN.
module int_mul_controller
   import mul_ctrl_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int MUL_LATENCY = 3,
   parameter int TAG_W       = 5
)(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              issue_valid_i,
   output logic              issue_ready_o,
   input  logic [1:0]        op_i,
   input  logic [XLEN-1:0]   operand1_i,
   input  logic [XLEN-1:0]   operand2_i,
   input  logic [TAG_W-1:0]  tag_i,
   input  logic              flush_i,
   output logic              mul_enable_o,
   output logic [XLEN-1:0]   mul_operand1_o,
   output logic [XLEN-1:0]   mul_operand2_o,
   input  logic [2*XLEN-1:0] mul_result_i,
   output logic              result_valid_o,
   input  logic              result_ready_i,
   output logic [XLEN-1:0]   result_o,
   output logic [TAG_W-1:0]  result_tag_o,
   output logic              busy_o
);

   if (!mul_latency_ok(MUL_LATENCY)) begin : g_bad_latency
      $error("int_mul_controller: MUL_LATENCY must be within 1..15");
   end
   if (XLEN != 32) begin : g_bad_xlen
      $error("int_mul_controller: only XLEN=32 is supported");
   end

   state_e            state_reg;
   logic [CNT_W-1:0]  cnt_reg;
   mul_op_e           op_reg;
   logic [TAG_W-1:0]  tag_reg;
   logic [TAG_W-1:0]  result_tag_reg;
   logic              neg_reg;
   logic              mul_enable_reg;
   logic [XLEN-1:0]   mag1_reg;
   logic [XLEN-1:0]   mag2_reg;
   logic [XLEN-1:0]   result_reg;

   mul_op_e           op_in;
   logic              sgn1;
   logic              sgn2;
   logic [XLEN-1:0]   mag1_next;
   logic [XLEN-1:0]   mag2_next;
   logic              neg_next;
   logic              accept;
   logic              wait_done;
   logic              hit;
   logic [2*XLEN-1:0] fix_prod;
   logic              fix_neg;
   mul_op_e           fix_op;
   logic [XLEN-1:0]   fix_result;

   assign issue_ready_o  = (state_reg == ST_IDLE) && !flush_i;
   assign busy_o         = (state_reg != ST_IDLE);
   assign result_valid_o = (state_reg == ST_DONE);
   assign mul_enable_o   = mul_enable_reg;
   assign mul_operand1_o = mag1_reg;
   assign mul_operand2_o = mag2_reg;
   assign result_o       = result_reg;
   assign result_tag_o   = result_tag_reg;

   assign accept    = issue_valid_i && issue_ready_o;
   assign wait_done = (state_reg == ST_WAIT) && (cnt_reg == '0);

   // MUL is handled as unsigned: its low word does not depend on signedness.
   always_comb begin
      op_in     = mul_op_e'(op_i);
      sgn1      = (op_in == OP_MULH) || (op_in == OP_MULHSU);
      sgn2      = (op_in == OP_MULH);
      mag1_next = (sgn1 && operand1_i[XLEN-1]) ? (~operand1_i + 1'b1) : operand1_i;
      mag2_next = (sgn2 && operand2_i[XLEN-1]) ? (~operand2_i + 1'b1) : operand2_i;
      neg_next  = (sgn1 && operand1_i[XLEN-1]) ^ (sgn2 && operand2_i[XLEN-1]);
   end

`ifdef MUL_RESULT_REUSE_EN
   logic              cache_valid_reg;
   logic [XLEN-1:0]   cache_op1_reg;
   logic [XLEN-1:0]   cache_op2_reg;
   mul_op_e           cache_opc_reg;
   logic [2*XLEN-1:0] cache_p_reg;
   logic [XLEN-1:0]   op1_reg;
   logic [XLEN-1:0]   op2_reg;
   logic [2*XLEN-1:0] p_corr;

   // A cached MULH/MULHSU/MULHU also serves a following MUL: the low word is shared.
   assign hit = cache_valid_reg && (operand1_i == cache_op1_reg) &&
                (operand2_i == cache_op2_reg) &&
                ((op_in == cache_opc_reg) || (op_in == OP_MUL));

   // In IDLE the fixup serves a cache hit; the cached product is already signed.
   assign fix_prod = (state_reg == ST_IDLE) ? cache_p_reg : mul_result_i;
   assign fix_neg  = (state_reg == ST_IDLE) ? 1'b0 : neg_reg;
   assign fix_op   = (state_reg == ST_IDLE) ? op_in : op_reg;
   assign p_corr   = neg_reg ? (~mul_result_i + 1'b1) : mul_result_i;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cache_valid_reg <= 1'b0;
         cache_op1_reg   <= '0;
         cache_op2_reg   <= '0;
         cache_opc_reg   <= OP_MUL;
         cache_p_reg     <= '0;
         op1_reg         <= '0;
         op2_reg         <= '0;
      end else if (flush_i) begin
         cache_valid_reg <= 1'b0;
      end else begin
         if (accept) begin
            op1_reg <= operand1_i;
            op2_reg <= operand2_i;
         end
         if (wait_done) begin
            cache_valid_reg <= 1'b1;
            cache_op1_reg   <= op1_reg;
            cache_op2_reg   <= op2_reg;
            cache_opc_reg   <= op_reg;
            cache_p_reg     <= p_corr;
         end
      end
   end
`else
   assign hit      = 1'b0;
   assign fix_prod = mul_result_i;
   assign fix_neg  = neg_reg;
   assign fix_op   = op_reg;
`endif

   mul_sign_fixup #(
      .XLEN     (XLEN)
   ) u_sign_fixup (
      .prod_i   (fix_prod),
      .neg_i    (fix_neg),
      .op_i     (fix_op),
      .result_o (fix_result)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_reg      <= ST_IDLE;
         cnt_reg        <= '0;
         op_reg         <= OP_MUL;
         tag_reg        <= '0;
         neg_reg        <= 1'b0;
         mul_enable_reg <= 1'b0;
         mag1_reg       <= '0;
         mag2_reg       <= '0;
         result_reg     <= '0;
         result_tag_reg <= '0;
      end else begin
         mul_enable_reg <= 1'b0;
         if (flush_i) begin
            state_reg <= ST_IDLE;
         end else begin
            case (state_reg)
               ST_IDLE: begin
                  if (accept) begin
                     op_reg   <= op_in;
                     tag_reg  <= tag_i;
                     neg_reg  <= neg_next;
                     mag1_reg <= mag1_next;
                     mag2_reg <= mag2_next;
                     if (hit) begin
                        result_reg     <= fix_result;
                        result_tag_reg <= tag_i;
                        state_reg      <= ST_DONE;
                     end else begin
                        mul_enable_reg <= 1'b1;
                        cnt_reg        <= CNT_W'(MUL_LATENCY);
                        state_reg      <= ST_WAIT;
                     end
                  end
               end
               ST_WAIT: begin
                  // The array output is valid in the cycle the counter reaches zero.
                  if (cnt_reg == '0) begin
                     result_reg     <= fix_result;
                     result_tag_reg <= tag_reg;
                     state_reg      <= ST_DONE;
                  end else begin
                     cnt_reg <= cnt_reg - 1'b1;
                  end
               end
               ST_DONE: begin
                  if (result_ready_i) begin
                     state_reg <= ST_IDLE;
                  end
               end
               default: state_reg <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_int_mul_controller.sv
// Scoreboard bench for int_mul_controller with a behavioural multiplier array.
// Build with +define+MUL_RESULT_REUSE_EN to exercise the reuse cache as well.
module tb_int_mul_controller;

   localparam int L     = 3;
   localparam int XLEN  = 32;
   localparam int TAG_W = 5;

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b0;
   logic              issue_valid_i = 1'b0;
   logic              issue_ready_o;
   logic [1:0]        op_i = 2'b00;
   logic [XLEN-1:0]   operand1_i = '0;
   logic [XLEN-1:0]   operand2_i = '0;
   logic [TAG_W-1:0]  tag_i = '0;
   logic              flush_i = 1'b0;
   logic              mul_enable_o;
   logic [XLEN-1:0]   mul_operand1_o;
   logic [XLEN-1:0]   mul_operand2_o;
   logic [2*XLEN-1:0] mul_result_i;
   logic              result_valid_o;
   logic              result_ready_i = 1'b1;
   logic [XLEN-1:0]   result_o;
   logic [TAG_W-1:0]  result_tag_o;
   logic              busy_o;

   int_mul_controller #(
      .XLEN           (XLEN),
      .MUL_LATENCY    (L),
      .TAG_W          (TAG_W)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .issue_valid_i  (issue_valid_i),
      .issue_ready_o  (issue_ready_o),
      .op_i           (op_i),
      .operand1_i     (operand1_i),
      .operand2_i     (operand2_i),
      .tag_i          (tag_i),
      .flush_i        (flush_i),
      .mul_enable_o   (mul_enable_o),
      .mul_operand1_o (mul_operand1_o),
      .mul_operand2_o (mul_operand2_o),
      .mul_result_i   (mul_result_i),
      .result_valid_o (result_valid_o),
      .result_ready_i (result_ready_i),
      .result_o       (result_o),
      .result_tag_o   (result_tag_o),
      .busy_o         (busy_o)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   // Array model: product of the magnitudes shows up L cycles after the enable
   // cycle; random junk otherwise so a mistimed sample is visible.
   logic [63:0] pipe [L];
   always @(posedge clk_i) begin
      pipe[0] <= mul_enable_o ? ({32'b0, mul_operand1_o} * {32'b0, mul_operand2_o})
                              : {$urandom, $urandom};
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
   end
   assign mul_result_i = pipe[L-1];

   int total = 0;
   int bad   = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [63:0] ea;
      logic [63:0] eb;
      logic [63:0] p;
      ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
      eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
      p  = ea * eb;
      return (op == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   typedef struct {
      logic [TAG_W-1:0] tag;
      logic [31:0]      val;
      int               acc;
      int               lat;
   } sb_t;

   sb_t sb [$];
   sb_t mon_e;
   int  en_cnt    = 0;
   int  valid_cnt = 0;

`ifdef MUL_RESULT_REUSE_EN
   bit          mc_valid = 1'b0;
   logic [31:0] mc_a = '0;
   logic [31:0] mc_b = '0;
   logic [1:0]  mc_op = '0;
`endif

   always @(negedge clk_i) begin
      if (mul_enable_o) en_cnt <= en_cnt + 1;
      if (result_valid_o) valid_cnt <= valid_cnt + 1;
      if (result_valid_o && result_ready_i) begin
         if (sb.size() == 0) begin
            check_val("unexpected_result", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            $display("txn tag=%0d result=0x%08h expected=0x%08h cycles=%0d",
                     result_tag_o, result_o, mon_e.val, cyc - mon_e.acc);
            check_val("result", result_o, mon_e.val);
            check_val("tag", result_tag_o, mon_e.tag);
            if (mon_e.lat != 0) check_val("latency", cyc - mon_e.acc, mon_e.lat);
         end
      end
   end

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, input bit lat_chk, output int acc);
      int  n;
      bit  hit;
      sb_t e;
      hit = 1'b0;
      acc = -1;
`ifdef MUL_RESULT_REUSE_EN
      hit = mc_valid && (a == mc_a) && (b == mc_b) && ((op == mc_op) || (op == 2'b00));
`endif
      @(posedge clk_i); #1;
      issue_valid_i = 1'b1;
      op_i = op; operand1_i = a; operand2_i = b; tag_i = tag;
      n = 0;
      do begin
         @(negedge clk_i);
         n++;
      end while (!issue_ready_o && n < 200);
      if (!issue_ready_o) begin
         check_val("issue_timeout", 0, 1);
      end else begin
         acc   = cyc;
         e.tag = tag;
         e.val = ref_mul(op, a, b);
         e.acc = cyc;
         e.lat = !lat_chk ? 0 : (hit ? 1 : L + 2);
         sb.push_back(e);
`ifdef MUL_RESULT_REUSE_EN
         if (!hit) begin
            mc_valid = 1'b1; mc_a = a; mc_b = b; mc_op = op;
         end
`endif
      end
      @(posedge clk_i); #1;
      issue_valid_i = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      check_val("drain", sb.size(), 0);
      @(posedge clk_i); #1;
   endtask

   task automatic check_reset_state();
      check_val("rst_issue_ready", issue_ready_o, 1);
      check_val("rst_enable", mul_enable_o, 0);
      check_val("rst_valid", result_valid_o, 0);
      check_val("rst_busy", busy_o, 0);
      check_val("rst_operand1", mul_operand1_o, 0);
      check_val("rst_operand2", mul_operand2_o, 0);
      check_val("rst_result", result_o, 0);
      check_val("rst_tag", result_tag_o, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc1, acc2, en0, v0, n;
      logic [31:0] pool [5];
      logic [31:0] a, b, expv;
      logic [1:0]  op;

      repeat (2) @(negedge clk_i);
      check_reset_state();
      @(posedge clk_i); #1;
      rst_i = 1'b1;

      // Basic ops and the enable pulse
      en0 = en_cnt;
      issue(2'b00, 32'hFFFFFFFF, 32'h00000002, 5'd3, 1'b1, acc1);
      check_val("enable_pulse", mul_enable_o, 1);
      drain();
      check_val("enable_count", en_cnt - en0, 1);
      issue(2'b01, 32'hFFFFFFFF, 32'h00000002, 5'd4, 1'b1, acc1); drain();
      issue(2'b11, 32'hFFFFFFFF, 32'h00000002, 5'd5, 1'b1, acc1); drain();
      issue(2'b01, 32'h80000000, 32'h80000000, 5'd6, 1'b1, acc1); drain();

      issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 5'd7, 1'b1, acc1);
      check_val("mulhsu_enable", mul_enable_o, 1);
      check_val("mulhsu_operand1", mul_operand1_o, 32'h80000000);
      check_val("mulhsu_operand2", mul_operand2_o, 32'hFFFFFFFF);
      drain();

      // Back-to-back spacing with result_ready held high
      issue(2'(($urandom_range(0, 3))), $urandom, $urandom, 5'd8, 1'b1, acc1);
      issue(2'(($urandom_range(0, 3))), $urandom, $urandom, 5'd9, 1'b1, acc2);
      check_val("b2b_spacing", acc2 - acc1, L + 3);
      drain();

      // Mixed ops over corner and random operands
      pool[0] = 32'h0; pool[1] = 32'h1; pool[2] = 32'hFFFFFFFF;
      pool[3] = 32'h80000000; pool[4] = 32'h7FFFFFFF;
      for (int i = 0; i < 16; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = ($urandom_range(0, 5) == 5) ? $urandom : pool[$urandom_range(0, 4)];
         b  = ($urandom_range(0, 5) == 5) ? $urandom : pool[$urandom_range(0, 4)];
         issue(op, a, b, 5'(16 + i), 1'b1, acc1);
         drain();
      end

      // Consumer stalls for four cycles in DONE
      result_ready_i = 1'b0;
      expv = ref_mul(2'b00, 32'h12345678, 32'h00000009);
      issue(2'b00, 32'h12345678, 32'h00000009, 5'd10, 1'b0, acc1);
      n = 0;
      while (!result_valid_o && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      check_val("stall_valid_seen", result_valid_o, 1);
      for (int k = 0; k < 4; k++) begin
         check_val("stall_result", result_o, expv);
         check_val("stall_tag", result_tag_o, 5'd10);
         check_val("stall_issue_ready", issue_ready_o, 0);
         @(negedge clk_i);
      end
      @(posedge clk_i); #1;
      result_ready_i = 1'b1;
      drain();

      // Flush while waiting on the array
      v0 = valid_cnt;
      issue(2'b00, 32'h00001111, 32'h00002222, 5'd11, 1'b0, acc1);
      @(posedge clk_i); #1;
      flush_i = 1'b1;
`ifdef MUL_RESULT_REUSE_EN
      mc_valid = 1'b0;
`endif
      @(negedge clk_i);
      check_val("flush_issue_ready", issue_ready_o, 0);
      @(posedge clk_i); #1;
      flush_i = 1'b0;
      @(negedge clk_i);
      check_val("flush_busy", busy_o, 0);
      check_val("flush_valid", result_valid_o, 0);
      void'(sb.pop_back());
      repeat (8) @(negedge clk_i);
      @(posedge clk_i); #1;
      check_val("flush_no_result", valid_cnt - v0, 0);

      // Flush and issue in the same cycle: the op is dropped
      en0 = en_cnt;
      issue_valid_i = 1'b1; flush_i = 1'b1;
      op_i = 2'b00; operand1_i = 32'h3; operand2_i = 32'h4;
      @(negedge clk_i);
      check_val("flush_issue_same_ready", issue_ready_o, 0);
      @(posedge clk_i); #1;
      issue_valid_i = 1'b0; flush_i = 1'b0;
      @(negedge clk_i);
      check_val("flush_issue_same_busy", busy_o, 0);
      @(posedge clk_i); #1;
      check_val("flush_issue_same_enable", en_cnt - en0, 0);

      // Asynchronous reset mid-WAIT
      issue(2'b01, 32'h00005555, 32'h00007777, 5'd12, 1'b0, acc1);
      @(posedge clk_i); #3;
      rst_i = 1'b0;
      #1;
      check_reset_state();
      void'(sb.pop_back());
`ifdef MUL_RESULT_REUSE_EN
      mc_valid = 1'b0;
`endif
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      v0 = valid_cnt;
      repeat (8) @(negedge clk_i);
      @(posedge clk_i); #1;
      check_val("reset_no_result", valid_cnt - v0, 0);
      issue(2'b00, 32'h00000003, 32'h00000005, 5'd13, 1'b1, acc1);
      drain();

`ifdef MUL_RESULT_REUSE_EN
      // Fused MULH;MUL pair hits the cache, MULHU on the same operands misses
      a = $urandom; b = $urandom;
      issue(2'b01, a, b, 5'd14, 1'b1, acc1); drain();
      en0 = en_cnt;
      issue(2'b00, a, b, 5'd15, 1'b1, acc1); drain();
      check_val("reuse_hit_no_enable", en_cnt - en0, 0);
      en0 = en_cnt;
      issue(2'b11, a, b, 5'd16, 1'b1, acc1); drain();
      check_val("reuse_miss_enable", en_cnt - en0, 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
